// File: rtl/axicb_arb_pkg.sv
// ============================================================================
// Module : axicb_arb_pkg
// Brief  : Shared FSM state type and width helpers for the QoS arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axicb_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    localparam int AGE_W = 8;

    // max(1, clog2(n)): used for PRIO_W, ID_W and level-index widths
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axicb_rr_picker.sv
// ============================================================================
// Module : axicb_rr_picker
// Brief  : Combinational round-robin pick, searching upward from ptr+1 with wrap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axicb_rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         vld
);

    logic [W-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(ptr) + k) % N);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axicb_qos_arbiter.sv
// ============================================================================
// Module : axicb_qos_arbiter
// Brief  : Static-priority round-robin arbiter with age-based promotion.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axicb_qos_arbiter
    import axicb_arb_pkg::*;
#(
    parameter int                                  REQ_NB       = 4,
    parameter int                                  PRIO_NB      = 4,
    parameter logic [REQ_NB*width_of(PRIO_NB)-1:0] REQ_PRIORITY = '0,
    parameter int                                  AGE_EN       = 1,
    parameter int                                  AGE_MAX      = 8
) (
    input  logic                        aclk,
    input  logic                        srst,
    input  logic                        en,
    input  logic [REQ_NB-1:0]           req,
    input  logic                        done,
    output logic [REQ_NB-1:0]           grant,
    output logic                        grant_vld,
    output logic [width_of(REQ_NB)-1:0] grant_id
);

    localparam int PRIO_W = width_of(PRIO_NB);
    localparam int ID_W   = width_of(REQ_NB);
    localparam int NLVL   = PRIO_NB + 1;
    localparam int LVL_W  = width_of(NLVL);

    for (genvar i = 0; i < REQ_NB; i++) begin : g_prio_chk
        if (int'(REQ_PRIORITY[i*PRIO_W +: PRIO_W]) >= PRIO_NB) begin : g_bad
            $error("REQ_PRIORITY field %0d exceeds PRIO_NB-1", i);
        end
    end

    arb_state_t        state_q, state_d;
    logic [REQ_NB-1:0] grant_q, grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q [NLVL];
    logic [ID_W-1:0]   ptr_d [NLVL];
    logic [AGE_W-1:0]  age_q [REQ_NB];
    logic [AGE_W-1:0]  age_d [REQ_NB];

    logic [REQ_NB-1:0] promoted;
    logic [REQ_NB-1:0] lvl_req [NLVL];
    logic [REQ_NB-1:0] lvl_gnt [NLVL];
    logic              lvl_vld [NLVL];
    logic [REQ_NB-1:0] win;
    logic [ID_W-1:0]   win_id;
    logic [LVL_W-1:0]  win_lvl;
    logic              win_vld;
    logic              gnt_evt;

    always_comb begin
        promoted = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            promoted[i] = (AGE_EN != 0) && (age_q[i] == AGE_W'(AGE_MAX));
        end
    end

    // Promoted requesters live only in the virtual level PRIO_NB
    always_comb begin
        for (int l = 0; l < NLVL; l++) begin
            lvl_req[l] = '0;
            for (int i = 0; i < REQ_NB; i++) begin
                lvl_req[l][i] = req[i] && (promoted[i] ? (l == PRIO_NB)
                                : (int'(REQ_PRIORITY[i*PRIO_W +: PRIO_W]) == l));
            end
        end
    end

    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        axicb_rr_picker #(
            .N (REQ_NB),
            .W (ID_W)
        ) u_pick (
            .req (lvl_req[l]),
            .ptr (ptr_q[l]),
            .gnt (lvl_gnt[l]),
            .vld (lvl_vld[l])
        );
    end

    always_comb begin
        win     = '0;
        win_lvl = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int l = 0; l < NLVL; l++) begin
            if (lvl_vld[l]) begin
                win     = lvl_gnt[l];
                win_lvl = LVL_W'(l);
                win_vld = 1'b1;
            end
        end
        for (int i = 0; i < REQ_NB; i++) begin
            if (win[i]) win_id = ID_W'(i);
        end
    end

    assign gnt_evt = en && win_vld && ((state_q == ST_IDLE) || done);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (gnt_evt) begin
            state_d        = ST_GRANTED;
            grant_d        = win;
            id_d           = win_id;
            ptr_d[win_lvl] = win_id;
        end else if ((state_q == ST_GRANTED) && done) begin
            state_d = ST_IDLE;
            grant_d = '0;
            id_d    = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < REQ_NB; i++) begin
            age_d[i] = age_q[i];
            if (AGE_EN == 0) begin
                age_d[i] = '0;
            end else if (gnt_evt && win[i]) begin
                age_d[i] = '0;
            end else if (gnt_evt && req[i]) begin
                if (age_q[i] != AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
            end else if (!req[i] && !((state_q == ST_GRANTED) && grant_q[i])) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            for (int l = 0; l < NLVL; l++) ptr_q[l] <= ID_W'(REQ_NB - 1);
            for (int i = 0; i < REQ_NB; i++) age_q[i] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            age_q   <= age_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vld = (state_q == ST_GRANTED);
    assign grant_id  = id_q;

endmodule

`default_nettype wire
